if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipelined CPU: owns the program counter, drives the
//  instruction memory and loads the IF/ID pipeline register feeding decode. Takes stall from
//  hazard detection and redirect from branch resolution. Stops fetching once a halt opcode is fetched.
// PARAMETERS
//  ADDR_W      16       PC / instruction-memory address width (word addressed)
//  INSTR_W     16       instruction width
//  RESET_PC    16'h0000 PC value after reset
//  HLT_OPCODE  4'hF     value of instr[15:12] that identifies HLT
//  NOP_INSTR   16'h0000 bubble pattern loaded into IF/ID (ADD R0,R0,R0)
// PORTS
//  clk            in   1        system clock; all state updates on rising edge
//  rst            in   1        reset; one clock; reset is synchronous and active-high
//  stall          in   1        hold PC and IF/ID (load-use hazard)
//  redirect       in   1        branch/jump taken; load PC from redirect_pc, squash IF/ID
//  redirect_pc    in   ADDR_W   redirect target
//  im_instr       in   INSTR_W  instruction-memory read data for im_addr, same cycle
//  im_addr        out  ADDR_W   instruction-memory address (= pc)
//  im_rd_en       out  1        instruction-memory read enable
//  pc             out  ADDR_W   current fetch PC
//  if_id_instr    out  INSTR_W  IF/ID instruction
//  if_id_pc_inc   out  ADDR_W   IF/ID PC+1 of that instruction (branch/JAL base)
//  if_id_valid    out  1        IF/ID holds a real instruction (0 = bubble)
//  fetch_halted   out  1        halt opcode fetched; fetch frozen
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_inc=0, if_id_valid=0,
//   fetch_halted=0. Reset overrides every other input.
//  Combinational: im_addr=pc; im_rd_en=~fetch_halted & ~stall. No combinational path from
//   stall/redirect to pc, if_id_*.
//  Per-edge priority (high->low): rst > redirect > fetch_halted > stall > normal fetch.
//  redirect: pc<=redirect_pc; IF/ID<=bubble (NOP_INSTR, valid 0, pc_inc 0); fetch_halted<=0
//   (a HLT fetched down a wrong path is squashed). redirect wins over a simultaneous stall.
//  fetch_halted (no redirect): pc holds; IF/ID<=bubble on the edge after a stall is released;
//   while stall=1 IF/ID holds its contents.
//  stall (no redirect, not halted): pc and all IF/ID fields hold their values.
//  normal: IF/ID<=im_instr, pc+1, valid 1. If im_instr[15:12]==HLT_OPCODE: fetch_halted<=1,
//   pc holds (HLT enters IF/ID exactly once); else pc<=pc+1.
//  Arithmetic: pc+1 is modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000 without a flag.
//  Fetch latency: instruction at pc appears in IF/ID one edge after fetch; a redirect costs one
//   bubble in IF/ID, plus the squash of ID/EX done outside this block.
//  rst asserted mid-stall or while halted: full reset state next edge, fetch resumes at RESET_PC.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: extra outputs perf_fetch_cnt[31:0] (edges taking the normal-fetch
//   path) and perf_stall_cnt[31:0] (edges with stall=1 & ~redirect & ~fetch_halted); both
//   reset to 0 and saturate at 32'hFFFFFFFF. Undefined: ports and counters absent,
//   behaviour otherwise identical.
// TESTING
//  1 rst 2 cycles, IM[0..2]=1111_xxxx... no: IM[0]=16'h1123,IM[1]=16'h2456 -> pc 0,1,2;
//    if_id_instr 1123 then 2456, if_id_pc_inc 1 then 2, valid=1.
//  2 stall=1 for 3 edges at pc=5 -> pc stays 5, IF/ID unchanged, im_rd_en=0; release -> pc=6.
//  3 redirect=1,redirect_pc=16'h0040 with stall=1 -> next pc=0040, if_id_valid=0,
//    if_id_instr=0000; next edge fetches IM[0x40].
//  4 IM[3]=16'hF000 -> fetch_halted=1 after edge, pc stuck at 3, HLT in IF/ID once then bubbles;
//    redirect to 0010 -> fetch_halted=0, fetch resumes at 0010.
//  5 redirect_pc=16'hFFFF, IM[FFFF]=16'h1000 -> pc wraps to 0000, if_id_pc_inc=0000.
//  6 rst asserted while halted and stalled -> all outputs at reset values next edge;
//    with IF_PERF_CNT_EN counters read 0, and count correctly through scenarios 1-2.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory drive and the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]        HLT_OPCODE = 4'hF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_inc,
  output logic               if_id_valid,
  output logic               fetch_halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [INSTR_W-1:0] r_if_id_instr;
  logic [INSTR_W-1:0] w_if_id_instr_nxt;
  logic [ADDR_W-1:0]  r_if_id_pc_inc;
  logic [ADDR_W-1:0]  w_if_id_pc_inc_nxt;
  logic               r_if_id_valid;
  logic               w_if_id_valid_nxt;
  logic [ADDR_W-1:0]  w_pc_plus1;
  logic               w_is_hlt;
  logic               w_fetch_go;
  logic               w_stall_go;

  // pc+1 wraps modulo 2^ADDR_W silently; the same value is the branch base in IF/ID.
  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_is_hlt   = (im_instr[INSTR_W-1 -: 4] == HLT_OPCODE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_if_id_instr_nxt  = r_if_id_instr;
    w_if_id_pc_inc_nxt = r_if_id_pc_inc;
    w_if_id_valid_nxt  = r_if_id_valid;
    w_fetch_go         = 1'b0;
    w_stall_go         = 1'b0;

    if (redirect) begin
      // A taken branch squashes IF/ID and any HLT fetched down the wrong path.
      w_state_nxt        = ST_FETCH;
      w_pc_nxt           = redirect_pc;
      w_if_id_instr_nxt  = NOP_INSTR;
      w_if_id_pc_inc_nxt = '0;
      w_if_id_valid_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_HALTED: begin
          if (!stall) begin
            w_if_id_instr_nxt  = NOP_INSTR;
            w_if_id_pc_inc_nxt = '0;
            w_if_id_valid_nxt  = 1'b0;
          end
        end
        ST_FETCH: begin
          if (stall) begin
            w_stall_go = 1'b1;
          end else begin
            w_fetch_go         = 1'b1;
            w_if_id_instr_nxt  = im_instr;
            w_if_id_pc_inc_nxt = w_pc_plus1;
            w_if_id_valid_nxt  = 1'b1;
            if (w_is_hlt) begin
              w_state_nxt = ST_HALTED;
            end else begin
              w_pc_nxt = w_pc_plus1;
            end
          end
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_FETCH;
      r_pc           <= RESET_PC;
      r_if_id_instr  <= NOP_INSTR;
      r_if_id_pc_inc <= '0;
      r_if_id_valid  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_if_id_instr  <= w_if_id_instr_nxt;
      r_if_id_pc_inc <= w_if_id_pc_inc_nxt;
      r_if_id_valid  <= w_if_id_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (w_fetch_go && (r_perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_stall_go && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

  assign pc           = r_pc;
  assign im_addr      = r_pc;
  assign fetch_halted = (r_state == ST_HALTED);
  assign im_rd_en     = ~fetch_halted & ~stall;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_pc_inc = r_if_id_pc_inc;
  assign if_id_valid  = r_if_id_valid;

endmodule
